// File: rtl/cmp_pkg.sv
// cmp_pkg: shared state encoding, size codes and round-robin pick for the compare arbiter
package cmp_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;
  localparam logic SZ_16 = 1'b0;
  localparam logic SZ_8  = 1'b1;
  // First set bit of mask scanning last+1, last+2, ... modulo n (n <= 8).
  // Walking the scan backwards lets the highest-priority hit overwrite the rest.
  function automatic logic [2:0] rr_pick(input logic [7:0] mask, input logic [2:0] last, input int n);
    logic [2:0] idx;
    int k;
    idx = last;
    for (int i = 8; i >= 1; i--) begin
      k = (int'(last) + i) % n;
      if (i <= n && mask[k[2:0]]) idx = k[2:0];
    end
    return idx;
  endfunction
endpackage

// File: rtl/cmp_arbiter_cmpunit.sv
// cmpUnit: full-width a - b with carry (NOT borrow) taken at the 8- or 16-bit boundary
//   a, b : operands
//   sz   : SZ_8 selects the byte boundary for the carry
//   diff : a - b modulo 2^DBW
//   c    : carry out, 1 when no borrow occurred
module cmpUnit
  import cmp_pkg::*;
#(
  parameter int DBW = 16
) (
  input  logic [DBW-1:0] a,
  input  logic [DBW-1:0] b,
  input  logic           sz,
  output logic [DBW-1:0] diff,
  output logic           c
);
  assign diff = a - b;
  assign c = (sz == SZ_8) ? (a[7:0] >= b[7:0]) : (a >= b);
endmodule

// File: rtl/cmp_arbiter.sv
// cmp_arbiter: round-robin sharing of one compare datapath between NREQ requesters
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   req, sz    : per-requester request (held until ack) and size (1 = 8-bit)
//   a, b       : packed operands, requester i at [i*DBW +: DBW]
//   ack        : one-hot one-cycle pulse marking valid results
//   res_o      : registered a - b, always full width
//   flag_n/z/c : sign, zero and carry at the selected boundary
//   busy       : high while an operation is executing or being acked
module cmp_arbiter
  import cmp_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DBW  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     sz,
  input  logic [NREQ*DBW-1:0] a,
  input  logic [NREQ*DBW-1:0] b,
  output logic [NREQ-1:0]     ack,
  output logic [DBW-1:0]      res_o,
  output logic                flag_n,
  output logic                flag_z,
  output logic                flag_c,
  output logic                busy
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  state_t state, state_nx;
  logic [GW-1:0] last, gid, pidx;
  logic [DBW-1:0] a_l, b_l, diff;
  logic sz_l, carry, win;
  logic [NREQ-1:0] cand;
  // The requester being acked in DONE still shows req, so it sits out this round.
  assign cand = (state == DONE) ? (req & ~(NREQ'(1) << gid)) : req;
  assign pidx = GW'(rr_pick(8'(cand), 3'(last), NREQ));
  assign win = (|cand) && (state != EXEC);
  assign busy = (state == EXEC) || (state == DONE);
  always_comb begin
    state_nx = IDLE;
    state_nx = (state == EXEC) ? DONE : win ? EXEC : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  cmpUnit #(.DBW(DBW)) u_cmp (
    .a(a_l),
    .b(b_l),
    .sz(sz_l),
    .diff(diff),
    .c(carry)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last   <= GW'(NREQ - 1);
      gid    <= '0;
      a_l    <= '0;
      b_l    <= '0;
      sz_l   <= SZ_16;
      ack    <= '0;
      res_o  <= '0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      ack <= (state == EXEC) ? (NREQ'(1) << gid) : '0;
      if (win) begin
        gid  <= pidx;
        last <= pidx;
        a_l  <= a[pidx*DBW +: DBW];
        b_l  <= b[pidx*DBW +: DBW];
        sz_l <= sz[pidx];
      end
      if (state == EXEC) begin
        res_o  <= diff;
        flag_n <= (sz_l == SZ_8) ? diff[7] : diff[DBW-1];
        flag_z <= (sz_l == SZ_8) ? (diff[7:0] == 8'd0) : (diff == '0);
        flag_c <= carry;
      end
    end
  end
endmodule
